echo_detector: RTL and testbench
================================

# echo_detector

Consumes the receive beamformer's aggregated waveform, one sample per `sample_valid_in`, and reports the first echo of each ping. It forms a rectified moving-average envelope, ignores a blanking interval after the burst, and detects threshold crossings with hysteresis. On each detected echo it emits a one-cycle pulse carrying the emission-relative timestamp and the peak envelope. It sits between `receive_beamformer` and `time_of_flight`, replacing the bare single-compare echo flag.

## Interface
- `DATA_WIDTH`, 16: sample and envelope width; samples are two's complement.
- `WINDOW_LOG2`, 3: moving-average window of 2^WINDOW_LOG2 samples.
- `THRESHOLD`, 5000: an echo starts when envelope > THRESHOLD.
- `HYSTERESIS`, 1000: an echo ends when envelope < THRESHOLD − HYSTERESIS.
- `BLANK_SAMPLES`, 64: valid samples ignored after `burst_start_in`; must be ≥ 2^WINDOW_LOG2.
- `TIME_WIDTH`, 24: timestamp width.

- `clk_in`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `burst_start_in`  in  1  one-cycle pulse marking the start of a new ping.
- `sample_in`  in  DATA_WIDTH  signed beamformed sample.
- `sample_valid_in`  in  1  qualifies `sample_in`.
- `time_in`  in  TIME_WIDTH  cycles since emission, sampled together with `sample_in`.
- `envelope_out`  out  DATA_WIDTH  current moving-average envelope (unsigned).
- `echo_valid_out`  out  1  one-cycle pulse; qualifies the two outputs below.
- `echo_time_out`  out  TIME_WIDTH  `time_in` of the sample whose envelope first exceeded THRESHOLD.
- `echo_peak_out`  out  DATA_WIDTH  maximum envelope seen during the echo.
- `armed_out`  out  1  high in state ARMED.

## Operation
- States: IDLE, BLANK, ARMED, ECHO, DONE. Reset enters IDLE.
- `burst_start_in` from any state:
  - clears the window buffer, running sum, blank counter and pipeline;
  - enters BLANK.
  - No output is produced for an aborted echo.
- Rectify: |x|. −2^(DATA_WIDTH−1) saturates to 2^(DATA_WIDTH−1)−1.
- Window:
  - circular buffer of 2^WINDOW_LOG2 rectified samples;
  - unsigned sum, DATA_WIDTH−1+WINDOW_LOG2 bits;
  - on each valid sample: sum ← sum + new − oldest;
  - envelope = sum >> WINDOW_LOG2.
- BLANK: counts valid samples, and the window still fills. After BLANK_SAMPLES samples, enter ARMED. Envelope is not compared.
- ARMED: on the first envelope update with envelope > THRESHOLD:
  - latch that sample's time into the echo timestamp;
  - set peak = envelope;
  - enter ECHO.
- ECHO: peak ← max(peak, envelope) on each update. On the first update with envelope < THRESHOLD − HYSTERESIS:
  - pulse `echo_valid_out` with the latched time and peak;
  - enter DONE.
- DONE: ignores all samples until `burst_start_in`. Only the first echo per ping is reported.
- IDLE: samples update the window, but no state change occurs.

## Timing
- All outputs reset to 0. `echo_time_out` and `echo_peak_out` hold their value until the next echo.
- Pipeline: a sample valid at cycle N is registered rectified at N+1. `envelope_out` updates at N+2.
- The ARMED→ECHO and ECHO→DONE decisions are registered at N+3. `echo_valid_out` is high exactly in cycle N+3 of the terminating sample.
- `time_in` is carried through the pipeline with its sample. The timestamp is the `time_in` present at cycle N.
- Back-to-back valid samples on every cycle are supported; throughput is 1 sample/cycle.
- `burst_start_in` coincident with `sample_valid_in`: the burst wins, the sample is dropped, and in-flight pipeline samples are discarded.
- `burst_start_in` in the same cycle a pulse would fire: the pulse is suppressed.
- Thresholds are compared as unsigned values, with strict > and <.
- Blank counter saturates and does not wrap.
- `rst_n` deassertion is synchronised internally; state is IDLE on the first active edge.

## Test plan
Defaults throughout.
- Reset:
  - assert `rst_n`=0 mid-ECHO → all outputs 0, state IDLE;
  - 10 valid samples of 8000 without burst → no `echo_valid_out`.
- Blanking:
  - burst, then 40 samples of 20000, then zeros → no echo;
  - `armed_out` rises after the 64th sample.
- Basic echo:
  - burst, 70 zeros, 16 samples of 8000 at time_in 1000..1015, then zeros → `echo_time_out`=1005 (6th sample, envelope 6000), `echo_peak_out`=8000;
  - pulse 3 cycles after the 5th zero sample (envelope 3000);
  - repeat with −8000 → identical result.
- Saturation and hysteresis:
  - −32768 samples → envelope 32767;
  - envelope driven to oscillate 4500↔5500 → exactly one echo, emitted only after envelope < 4000.
- Abort and DONE:
  - burst asserted mid-ECHO → no pulse, state BLANK;
  - after a completed echo, a second 8000 burst of samples → no second pulse until the next `burst_start_in`.
- Coincidence: `burst_start_in` and `sample_valid_in` in the same cycle → sample ignored, blank count starts at 0.

Source files
------------

// File: rtl/echo_detector.sv
// Echo detector: rectified moving-average envelope, post-burst blanking and
// hysteresis threshold detection; reports the first echo of each ping.
module echo_detector #(
  parameter int DATA_WIDTH    = 16,
  parameter int WINDOW_LOG2   = 3,
  parameter int THRESHOLD     = 5000,
  parameter int HYSTERESIS    = 1000,
  parameter int BLANK_SAMPLES = 64,
  parameter int TIME_WIDTH    = 24
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  burst_start_in,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid_in,
  input  logic [TIME_WIDTH-1:0] time_in,
  output logic [DATA_WIDTH-1:0] envelope_out,
  output logic                  echo_valid_out,
  output logic [TIME_WIDTH-1:0] echo_time_out,
  output logic [DATA_WIDTH-1:0] echo_peak_out,
  output logic                  armed_out
);

  localparam int RW    = DATA_WIDTH - 1;
  localparam int DEPTH = 1 << WINDOW_LOG2;
  localparam int SUM_W = DATA_WIDTH - 1 + WINDOW_LOG2;
  localparam int CNT_W = $clog2(BLANK_SAMPLES + 1);
  localparam logic [DATA_WIDTH-1:0] HI      = DATA_WIDTH'(THRESHOLD);
  localparam logic [DATA_WIDTH-1:0] LO      = DATA_WIDTH'(THRESHOLD - HYSTERESIS);
  localparam logic [DATA_WIDTH-1:0] NEG_MAX = {1'b1, {RW{1'b0}}};
  localparam logic [CNT_W-1:0]      BLANK_N = CNT_W'(BLANK_SAMPLES);

  typedef enum logic [2:0] {IDLE, BLANK, ARMED, ECHO, DONE} state_t;

  logic                   rst_meta, rst_sync;
  logic [RW-1:0]          rect;
  logic                   v1, v2;
  logic [RW-1:0]          rect1;
  logic [TIME_WIDTH-1:0]  t1, t2;
  logic [RW-1:0]          buffer [DEPTH];
  logic [WINDOW_LOG2-1:0] ptr;
  logic [SUM_W-1:0]       sum;
  state_t                 state;
  logic [CNT_W-1:0]       blank_cnt;
  logic [TIME_WIDTH-1:0]  time_lat;
  logic [DATA_WIDTH-1:0]  peak;

  // Assert asynchronously, release on the clock.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  // Most negative input has no positive counterpart; clamp it to full scale.
  always_comb begin
    rect = sample_in[RW-1:0];
    if (sample_in == NEG_MAX)
      rect = '1;
    else if (sample_in[DATA_WIDTH-1])
      rect = RW'(-sample_in);
  end

  assign envelope_out = {1'b0, sum[SUM_W-1:WINDOW_LOG2]};
  assign armed_out    = (state == ARMED);

  always_ff @(posedge clk_in or negedge rst_sync) begin
    if (!rst_sync) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      rect1 <= '0;
      t1    <= '0;
      t2    <= '0;
      ptr   <= '0;
      sum   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) buffer[i] <= '0;
    end else if (burst_start_in) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      ptr <= '0;
      sum <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) buffer[i] <= '0;
    end else begin
      v1    <= sample_valid_in;
      rect1 <= rect;
      t1    <= time_in;
      v2    <= v1;
      t2    <= t1;
      if (v1) begin
        buffer[ptr] <= rect1;
        sum         <= sum + SUM_W'(rect1) - SUM_W'(buffer[ptr]);
        ptr         <= ptr + WINDOW_LOG2'(1);
      end
    end
  end

  // v2 marks the cycle in which envelope_out reflects the newest sample.
  always_ff @(posedge clk_in or negedge rst_sync) begin
    if (!rst_sync) begin
      state          <= IDLE;
      blank_cnt      <= '0;
      time_lat       <= '0;
      peak           <= '0;
      echo_valid_out <= 1'b0;
      echo_time_out  <= '0;
      echo_peak_out  <= '0;
    end else begin
      echo_valid_out <= 1'b0;
      if (burst_start_in) begin
        state     <= BLANK;
        blank_cnt <= '0;
      end else if (v2) begin
        case (state)
          BLANK: begin
            if (blank_cnt != BLANK_N) blank_cnt <= blank_cnt + CNT_W'(1);
            if (blank_cnt >= BLANK_N - CNT_W'(1)) state <= ARMED;
          end
          ARMED: begin
            if (envelope_out > HI) begin
              time_lat <= t2;
              peak     <= envelope_out;
              state    <= ECHO;
            end
          end
          ECHO: begin
            if (envelope_out < LO) begin
              echo_valid_out <= 1'b1;
              echo_time_out  <= time_lat;
              echo_peak_out  <= peak;
              state          <= DONE;
            end else if (envelope_out > peak) begin
              peak <= envelope_out;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_echo_detector.sv
// Directed bench for echo_detector: a table of single-ping echo scenarios
// plus hand-written sequences for blanking, hysteresis, abort and reset.
module tb_echo_detector;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        burst_start_in;
  logic [15:0] sample_in;
  logic        sample_valid_in;
  logic [23:0] time_in;
  logic [15:0] envelope_out;
  logic        echo_valid_out;
  logic [23:0] echo_time_out;
  logic [15:0] echo_peak_out;
  logic        armed_out;

  echo_detector #(
    .DATA_WIDTH(16), .WINDOW_LOG2(3), .THRESHOLD(5000),
    .HYSTERESIS(1000), .BLANK_SAMPLES(64), .TIME_WIDTH(24)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .burst_start_in(burst_start_in),
    .sample_in(sample_in), .sample_valid_in(sample_valid_in), .time_in(time_in),
    .envelope_out(envelope_out), .echo_valid_out(echo_valid_out),
    .echo_time_out(echo_time_out), .echo_peak_out(echo_peak_out),
    .armed_out(armed_out)
  );

  always #5 clk_in = ~clk_in;

  int vectors = 0, miscompares = 0;
  int cyc = 0, pulses = 0, p_time = 0, p_peak = 0, p_cyc = 0, last_cap = 0;

  // Edge counter and pulse recorder, sampled just after each rising edge.
  always @(posedge clk_in) begin
    #1;
    cyc = cyc + 1;
    if (echo_valid_out) begin
      pulses = pulses + 1;
      p_time = int'(echo_time_out);
      p_peak = int'(echo_peak_out);
      p_cyc  = cyc;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit b, input bit v, input int s, input int t);
    @(negedge clk_in);
    burst_start_in  = b;
    sample_valid_in = v;
    sample_in       = 16'(s);
    time_in         = 24'(t);
    last_cap        = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 0, 0);
  endtask

  task automatic zeros(input int n);
    repeat (n) step(1'b0, 1'b1, 0, 0);
  endtask

  typedef struct {
    int level;
    int n_high;
    int t0;
    int exp_env;
    int exp_pulses;
    int exp_time;
    int exp_peak;
    int exp_term;   // 1-based trailing zero that ends the echo
  } vec_t;

  vec_t vecs [5];
  int   zc [12];
  int   p0, t;

  initial begin
    vecs[0] = '{ 8000,   16, 1000,  8000, 1, 1005,  8000, 5};
    vecs[1] = '{-8000,   16, 1000,  8000, 1, 1005,  8000, 5};
    vecs[2] = '{ 5000,   16, 2000,  5000, 0,    0,     0, 0};
    vecs[3] = '{ 5008,   16, 3000,  5008, 1, 3007,  5008, 2};
    vecs[4] = '{-32768,  16,  500, 32767, 1,  501, 32767, 8};

    rst_n = 1'b0; burst_start_in = 1'b0; sample_valid_in = 1'b0;
    sample_in = '0; time_in = '0;
    repeat (3) @(negedge clk_in);
    check("rst_env",   envelope_out,   0);
    check("rst_valid", echo_valid_out, 0);
    check("rst_time",  echo_time_out,  0);
    check("rst_peak",  echo_peak_out,  0);
    check("rst_armed", armed_out,      0);
    rst_n = 1'b1;
    idle(3);

    // IDLE: window follows the input but nothing is detected.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8000, i);
    idle(3);
    check("idle_env", envelope_out, 8000);
    check("idle_no_echo", pulses, 0);

    for (int i = 0; i < 5; i++) begin
      p0 = pulses;
      step(1'b1, 1'b0, 0, 0);
      for (int j = 0; j < 70; j++) step(1'b0, 1'b1, 0, j);
      for (int k = 0; k < vecs[i].n_high; k++)
        step(1'b0, 1'b1, vecs[i].level, vecs[i].t0 + k);
      idle(2);
      check($sformatf("v%0d_env", i), envelope_out, vecs[i].exp_env);
      for (int j = 0; j < 12; j++) begin
        step(1'b0, 1'b1, 0, vecs[i].t0 + vecs[i].n_high + j);
        zc[j] = last_cap;
      end
      idle(4);
      check($sformatf("v%0d_pulses", i), pulses - p0, vecs[i].exp_pulses);
      if (vecs[i].exp_pulses == 1) begin
        check($sformatf("v%0d_time", i), p_time, vecs[i].exp_time);
        check($sformatf("v%0d_peak", i), p_peak, vecs[i].exp_peak);
        check($sformatf("v%0d_lat", i), p_cyc, zc[vecs[i].exp_term-1] + 2);
      end
    end

    // DONE ignores a second echo until the next burst.
    p0 = pulses;
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 8000, 9000 + k);
    zeros(12);
    idle(4);
    check("done_no_second", pulses - p0, 0);
    check("done_peak_hold", echo_peak_out, 32767);
    step(1'b1, 1'b0, 0, 0);
    zeros(70);
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 8000, 1000 + k);
    zeros(12);
    idle(4);
    check("rearm_pulses", pulses - p0, 1);
    check("rearm_time", echo_time_out, 1005);

    // Hysteresis: envelope ramps 4500 <-> 5500 three times, then drops.
    p0 = pulses;
    step(1'b1, 1'b0, 0, 0);
    t = 7000;
    for (int k = 0; k < 64; k++) begin step(1'b0, 1'b1, 4500, t); t++; end
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 8; k++) begin step(1'b0, 1'b1, 5500, t); t++; end
      for (int k = 0; k < 8; k++) begin step(1'b0, 1'b1, 4500, t); t++; end
    end
    idle(4);
    check("osc_no_early", pulses - p0, 0);
    for (int j = 0; j < 12; j++) begin step(1'b0, 1'b1, 0, t); t++; zc[j] = last_cap; end
    idle(4);
    check("osc_pulses", pulses - p0, 1);
    check("osc_time", p_time, 7068);
    check("osc_peak", p_peak, 5500);
    check("osc_lat", p_cyc, zc[0] + 2);

    // Blanking: loud samples inside the blank window are ignored.
    p0 = pulses;
    step(1'b1, 1'b0, 0, 0);
    for (int k = 0; k < 40; k++) step(1'b0, 1'b1, 20000, k);
    zeros(23);
    idle(3);
    check("blank_63_armed", armed_out, 0);
    zeros(1);
    idle(3);
    check("blank_64_armed", armed_out, 1);
    check("blank_env", envelope_out, 0);
    zeros(12);
    idle(4);
    check("blank_no_echo", pulses - p0, 0);

    // Abort mid-echo with a coincident valid sample.
    p0 = pulses;
    step(1'b1, 1'b0, 0, 0);
    zeros(70);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 8000, 100 + k);
    step(1'b1, 1'b1, 8000, 200);
    idle(2);
    check("abort_env", envelope_out, 0);
    check("abort_armed", armed_out, 0);
    zeros(63);
    idle(3);
    check("coin_63_armed", armed_out, 0);
    zeros(1);
    idle(3);
    check("coin_64_armed", armed_out, 1);
    zeros(12);
    idle(4);
    check("abort_no_pulse", pulses - p0, 0);

    // Burst on the very edge a pulse would fire.
    p0 = pulses;
    step(1'b1, 1'b0, 0, 0);
    zeros(70);
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 8000, 300 + k);
    zeros(5);
    idle(1);
    step(1'b1, 1'b0, 0, 0);
    idle(4);
    check("supp_no_pulse", pulses - p0, 0);
    check("supp_time_hold", echo_time_out, 7068);

    // Reset mid-echo.
    step(1'b1, 1'b0, 0, 0);
    zeros(70);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 8000, 400 + k);
    idle(3);
    @(negedge clk_in);
    rst_n = 1'b0;
    #1;
    check("mid_rst_env",   envelope_out,   0);
    check("mid_rst_valid", echo_valid_out, 0);
    check("mid_rst_time",  echo_time_out,  0);
    check("mid_rst_peak",  echo_peak_out,  0);
    check("mid_rst_armed", armed_out,      0);
    p0 = pulses;
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    idle(3);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8000, i);
    idle(3);
    check("post_rst_env", envelope_out, 8000);
    zeros(12);
    idle(4);
    check("post_rst_no_echo", pulses - p0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
